// File: rtl/axi_arbiter_pkg.sv
// Shared widths and types for the arbiter / demux pair on the AXI-stream return path.
package axi_arbiter_pkg;

    localparam int unsigned DATA_SIZE       = 32;
    localparam int unsigned ID_SIZE         = 8;
    localparam int unsigned NUM_CHANNELS    = 4;
    localparam int unsigned CHANNELS_W      = $clog2(NUM_CHANNELS);
    localparam int unsigned MAX_PACKET_SIZE = 4;
    localparam int unsigned FIFO_DEPTH      = 4;
    localparam int unsigned BEAT_CNT_W      = $clog2(MAX_PACKET_SIZE) + 1;

    // idx_channel is the low ID slice that selects the output channel
    typedef struct packed {
        logic [ID_SIZE-CHANNELS_W-1:0] id_hi;
        logic [CHANNELS_W-1:0]         idx_channel;
        logic [DATA_SIZE-1:0]          data;
    } axi_data_t;

    typedef struct packed {
        axi_data_t beat;
        logic      last;
    } axi_beat_t;

    typedef enum logic {IDLE, BUSY} demux_state_t;

endpackage

// File: rtl/axi_demux_fifo.sv
// Single-clock FIFO of stream beats; one instance per demux output.
module axi_demux_fifo
    import axi_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  axi_beat_t wdata,
    input  logic      pop,
    output axi_beat_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    axi_beat_t        mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the addresses match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign rdata = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= wdata;
                wr_ptr                  <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_demux.sv
// 1-to-NUM_CHANNELS stream demux: routes each packet by the ID of its first beat
// into a per-output FIFO, capping packets at MAX_PACKET_SIZE beats.
module axi_demux #(
    parameter int unsigned DATA_SIZE       = axi_arbiter_pkg::DATA_SIZE,
    parameter int unsigned ID_SIZE         = axi_arbiter_pkg::ID_SIZE,
    parameter int unsigned NUM_CHANNELS    = axi_arbiter_pkg::NUM_CHANNELS,
    parameter int unsigned MAX_PACKET_SIZE = axi_arbiter_pkg::MAX_PACKET_SIZE,
    parameter int unsigned FIFO_DEPTH      = axi_arbiter_pkg::FIFO_DEPTH
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_SIZE-1:0]            s_data,
    input  logic [ID_SIZE-1:0]              s_id,
    input  logic                            s_last,
    output logic [NUM_CHANNELS-1:0]         m_valid,
    input  logic [NUM_CHANNELS-1:0]         m_ready,
    output logic [NUM_CHANNELS*DATA_SIZE-1:0] m_data,
    output logic [NUM_CHANNELS*ID_SIZE-1:0] m_id,
    output logic [NUM_CHANNELS-1:0]         m_last,
    output logic                            pkt_err
);

    import axi_arbiter_pkg::*;

    localparam int unsigned CHANNELS_W = $clog2(NUM_CHANNELS);
    localparam int unsigned BEAT_CNT_W = $clog2(MAX_PACKET_SIZE) + 1;

    demux_state_t          state_q;
    demux_state_t          state_d;
    logic [CHANNELS_W-1:0] dest_q;
    logic [CHANNELS_W-1:0] dest_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q;
    logic [BEAT_CNT_W-1:0] beat_cnt_d;
    logic                  pkt_err_q;
    logic                  pkt_err_d;

    logic [CHANNELS_W-1:0] dest;
    logic                  accept;
    logic                  last_eff;
    axi_beat_t             wbeat;

    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] pop;
    logic [NUM_CHANNELS-1:0] full;
    logic [NUM_CHANNELS-1:0] empty;
    axi_beat_t               head [NUM_CHANNELS];

    // Routing is locked to dest_q for the remainder of an open packet
    always_comb begin
        dest     = (state_q == BUSY) ? dest_q : s_id[CHANNELS_W-1:0];
        s_ready  = !full[dest];
        accept   = s_valid && s_ready;
        last_eff = s_last || (beat_cnt_q == BEAT_CNT_W'(MAX_PACKET_SIZE - 1));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            dest_q     <= '0;
            beat_cnt_q <= '0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        beat_cnt_d = beat_cnt_q;
        pkt_err_d  = 1'b0;
        if (accept) begin
            if (last_eff) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                pkt_err_d  = !s_last;
            end else begin
                state_d    = BUSY;
                dest_d     = dest;
                beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end
        end
    end

    assign pkt_err = pkt_err_q;

    // Stored ID is the beat's own ID; a capped packet's final beat carries last
    assign wbeat = '{beat: '{id_hi:       s_id[ID_SIZE-1:CHANNELS_W],
                             idx_channel: s_id[CHANNELS_W-1:0],
                             data:        s_data},
                     last: last_eff};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign push[i] = accept && (dest == CHANNELS_W'(i));
        assign pop[i]  = m_ready[i] && !empty[i];

        axi_demux_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (aclk),
            .rst_n (aresetn),
            .push  (push[i]),
            .wdata (wbeat),
            .pop   (pop[i]),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );

        assign m_valid[i]                          = !empty[i];
        assign m_last[i]                           = head[i].last;
        assign m_data[i*DATA_SIZE +: DATA_SIZE]    = head[i].beat.data;
        assign m_id[i*ID_SIZE +: ID_SIZE]          = {head[i].beat.id_hi, head[i].beat.idx_channel};
    end

endmodule

// File: tb/tb_axi_demux.sv
// Directed bench for axi_demux: routing table plus backpressure, HOL and reset sequences.
module tb_axi_demux;

    logic         aclk;
    logic         aresetn;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [7:0]   s_id;
    logic         s_last;
    logic [3:0]   m_valid;
    logic [3:0]   m_ready;
    logic [127:0] m_data;
    logic [31:0]  m_id;
    logic [3:0]   m_last;
    logic         pkt_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] q0[$];

    axi_demux dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_id    (s_id),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_id    (m_id),
        .m_last  (m_last),
        .pkt_err (pkt_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Record every beat consumed from output 0
    always @(negedge aclk) begin
        if (aresetn && m_valid[0] && m_ready[0]) q0.push_back(m_data[31:0]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic [7:0]  id;
        logic [31:0] d;
        logic        l;
        logic [3:0]  mv;
        logic [3:0]  ml;
        logic        err;
        int          ch;
        logic [7:0]  eid;
    } row_t;

    row_t rows [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] id, input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_id    = id;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got s_ready 0 expected 1");
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 4'hF;
        repeat (8) step();
    endtask

    initial begin
        rows[0]  = '{1'b1, 8'h02, 32'hDEADBEEF, 1'b1, 4'b0100, 4'b0100, 1'b0, 2, 8'h02};
        rows[1]  = '{1'b1, 8'h01, 32'h11111111, 1'b0, 4'b0010, 4'b0000, 1'b0, 1, 8'h01};
        rows[2]  = '{1'b1, 8'h03, 32'h22222222, 1'b0, 4'b0010, 4'b0000, 1'b0, 1, 8'h03};
        rows[3]  = '{1'b1, 8'h03, 32'h33333333, 1'b1, 4'b0010, 4'b0010, 1'b0, 1, 8'h03};
        rows[4]  = '{1'b1, 8'h01, 32'h000000A1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1, 8'h01};
        rows[5]  = '{1'b1, 8'h01, 32'h000000A2, 1'b0, 4'b0010, 4'b0000, 1'b0, 1, 8'h01};
        rows[6]  = '{1'b1, 8'h01, 32'h000000A3, 1'b0, 4'b0010, 4'b0000, 1'b0, 1, 8'h01};
        rows[7]  = '{1'b1, 8'h01, 32'h000000A4, 1'b0, 4'b0010, 4'b0010, 1'b1, 1, 8'h01};
        rows[8]  = '{1'b1, 8'h03, 32'h000000A5, 1'b0, 4'b1000, 4'b0000, 1'b0, 3, 8'h03};
        rows[9]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, -1, 8'h00};
        rows[10] = '{1'b1, 8'h03, 32'h000000A6, 1'b1, 4'b1000, 4'b1000, 1'b0, 3, 8'h03};
        rows[11] = '{1'b1, 8'h00, 32'h00000005, 1'b1, 4'b0001, 4'b0001, 1'b0, 0, 8'h00};

        aresetn = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_id    = '0;
        s_last  = 1'b0;
        m_ready = 4'hF;
        repeat (2) step();

        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 4'b0000);
        check("rst_m_last",  m_last,  4'b0000);
        check("rst_m_data",  m_data,  128'h0);
        check("rst_m_id",    m_id,    32'h0);
        check("rst_pkt_err", pkt_err, 1'b0);
        aresetn = 1'b1;
        step();

        // Routing / packet lock / overlong packet, all outputs ready
        for (int i = 0; i < 12; i++) begin
            s_valid = rows[i].v;
            s_id    = rows[i].id;
            s_data  = rows[i].d;
            s_last  = rows[i].l;
            #1;
            check($sformatf("row%0d_s_ready", i), s_ready, 1'b1);
            step();
            check($sformatf("row%0d_m_valid", i), m_valid, rows[i].mv);
            check($sformatf("row%0d_m_last", i),  m_last,  rows[i].ml);
            check($sformatf("row%0d_pkt_err", i), pkt_err, rows[i].err);
            if (rows[i].ch >= 0) begin
                check($sformatf("row%0d_m_data", i), m_data[rows[i].ch*32 +: 32], rows[i].d);
                check($sformatf("row%0d_m_id", i),   m_id[rows[i].ch*8 +: 8],     rows[i].eid);
            end
        end
        drain();

        // Backpressure on output 0
        q0.delete();
        m_ready = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_id    = 8'h00;
            s_last  = 1'b1;
            s_data  = 32'hB0000000 + 32'(k);
            #1;
            check($sformatf("bp_ready%0d", k), s_ready, 1'b1);
            step();
        end
        s_data = 32'hB0000004;
        #1;
        check("bp_full",   s_ready, 1'b0);
        check("bp_mvalid", m_valid, 4'b0001);
        step();
        check("bp_hold", s_ready, 1'b0);
        m_ready = 4'hF;
        #1;
        check("bp_pop_cycle", s_ready, 1'b0);
        step();
        check("bp_rise", s_ready, 1'b1);
        send(8'h00, 32'hB0000004, 1'b1);
        send(8'h00, 32'hB0000005, 1'b1);
        for (int n = 0; n < 20 && q0.size() < 6; n++) step();
        check("bp_count", q0.size(), 6);
        for (int k = 0; k < 6 && k < q0.size(); k++) begin
            check($sformatf("bp_order%0d", k), q0[k], 32'hB0000000 + 32'(k));
        end
        drain();

        // Head-of-line blocking: ch2 beat stuck behind a beat for full ch0
        q0.delete();
        m_ready = 4'b1110;
        for (int k = 0; k < 4; k++) send(8'h00, 32'hC0000000 + 32'(k), 1'b1);
        s_valid = 1'b1;
        s_id    = 8'h00;
        s_data  = 32'hC0000004;
        s_last  = 1'b1;
        #1;
        check("hol_blocked", s_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hol_ch2_idle%0d", k), m_valid[2], 1'b0);
        end
        m_ready = 4'hF;
        send(8'h00, 32'hC0000004, 1'b1);
        send(8'h02, 32'hD0000000, 1'b1);
        check("hol_ch2_valid", m_valid[2], 1'b1);
        check("hol_ch2_data",  m_data[95:64], 32'hD0000000);
        drain();
        check("hol_ch0_count", q0.size(), 5);

        // Reset in the middle of a packet with beats still queued
        m_ready = 4'b0000;
        send(8'h01, 32'hE0000000, 1'b0);
        send(8'h01, 32'hE0000001, 1'b0);
        check("rmp_queued", m_valid, 4'b0010);
        aresetn = 1'b0;
        s_id    = 8'h03;
        #1;
        check("rmp_m_valid", m_valid, 4'b0000);
        check("rmp_s_ready", s_ready, 1'b1);
        check("rmp_pkt_err", pkt_err, 1'b0);
        step();
        step();
        aresetn = 1'b1;
        step();
        send(8'h03, 32'hF0000000, 1'b1);
        check("rmp_route",   m_valid, 4'b1000);
        check("rmp_data",    m_data[127:96], 32'hF0000000);
        check("rmp_no_err",  pkt_err, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
